// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core definitions for the writeback arbiter: widths and source encoding.
package regfile_wb_arbiter_pkg;

    localparam int INT32W       = 32;
    localparam int REGFILE_SIZE = 5;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: ALU/LSU handshakes, issue marks, register-file write port and forwarding.
interface regfile_wb_arbiter_if #(
    parameter int INT32W       = regfile_wb_arbiter_pkg::INT32W,
    parameter int REGFILE_SIZE = regfile_wb_arbiter_pkg::REGFILE_SIZE
);
    logic                        a_valid;
    logic                        a_ready;
    logic [REGFILE_SIZE-1:0]     a_rd;
    logic [INT32W-1:0]           a_data;
    logic                        b_valid;
    logic                        b_ready;
    logic [REGFILE_SIZE-1:0]     b_rd;
    logic [INT32W-1:0]           b_data;
    logic [REGFILE_SIZE-1:0]     rd;
    logic [INT32W-1:0]           dataRd;
    logic                        iss_valid;
    logic [REGFILE_SIZE-1:0]     iss_rd;
    logic [(1<<REGFILE_SIZE)-1:0] pend_mask;
    logic                        byp_valid;
    logic [REGFILE_SIZE-1:0]     byp_rd;
    logic [INT32W-1:0]           byp_data;

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        input  a_ready, b_ready, rd, dataRd, pend_mask, byp_valid, byp_rd, byp_data
    );

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        output a_ready, b_ready, rd, dataRd, pend_mask, byp_valid, byp_rd, byp_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-input round-robin arbiter; the pointer hands priority to the loser after every grant.
module wb_rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_a_valid,
    input  logic i_b_valid,
    output logic o_a_grant,
    output logic o_b_grant
);

    src_e r_ptr;
    src_e w_ptr_nxt;
    logic w_a_grant;
    logic w_b_grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= SRC_A;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Grants are forced low while reset is held so no handshake completes.
    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        w_ptr_nxt = r_ptr;
        if (reset) begin
            if (i_a_valid && (!i_b_valid || r_ptr == SRC_A)) begin
                w_a_grant = 1'b1;
            end else if (i_b_valid) begin
                w_b_grant = 1'b1;
            end
            if (w_a_grant) begin
                w_ptr_nxt = other_src(SRC_A);
            end else if (w_b_grant) begin
                w_ptr_nxt = other_src(SRC_B);
            end
        end
    end

    assign o_a_grant = w_a_grant;
    assign o_b_grant = w_b_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU writebacks onto one register-file write port and tracks pending destinations.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int INT32W       = regfile_wb_arbiter_pkg::INT32W,
    parameter int REGFILE_SIZE = regfile_wb_arbiter_pkg::REGFILE_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int NREG = 1 << REGFILE_SIZE;

    logic                    w_a_grant;
    logic                    w_b_grant;
    logic [REGFILE_SIZE-1:0] r_rd;
    logic [INT32W-1:0]       r_data;
    logic [NREG-1:0]         r_pend;
    logic [NREG-1:0]         w_pend_nxt;

    wb_rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_a_valid (bus.a_valid),
        .i_b_valid (bus.b_valid),
        .o_a_grant (w_a_grant),
        .o_b_grant (w_b_grant)
    );

    // No grant loads the idle encoding, since the register file has no write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd   <= '0;
            r_data <= '0;
        end else if (w_a_grant) begin
            r_rd   <= bus.a_rd;
            r_data <= bus.a_data;
        end else if (w_b_grant) begin
            r_rd   <= bus.b_rd;
            r_data <= bus.b_data;
        end else begin
            r_rd   <= '0;
            r_data <= '0;
        end
    end

    // Set is applied after clear so a re-issue on the commit edge keeps the bit.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_rd != '0) begin
            w_pend_nxt[r_rd] = 1'b0;
        end
        if (bus.iss_valid && bus.iss_rd != '0) begin
            w_pend_nxt[bus.iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    assign bus.a_ready   = w_a_grant;
    assign bus.b_ready   = w_b_grant;
    assign bus.rd        = r_rd;
    assign bus.dataRd    = r_data;
    assign bus.pend_mask = r_pend;
    assign bus.byp_valid = (r_rd != '0);
    assign bus.byp_rd    = r_rd;
    assign bus.byp_data  = r_data;

endmodule
